coefficient_reconstruction: RTL and testbench
=============================================

COEFFICIENT_RECONSTRUCTION -- requirements
Module: coefficient_reconstruction

Interface
REQ-001 SHALL have parameter WIDTH, default 16, coefficient bit width (signed).
REQ-002 SHALL have parameter DEPTH, default 8, block dimension (DEPTH x DEPTH coefficients, power of two).
REQ-003 SHALL have parameter INDEX_WIDTH, default 2*$clog2(DEPTH), coefficient position: upper half = column, lower half = row.
REQ-004 SHALL have port clk, input, 1, clock; all state updates on rising edge.
REQ-005 SHALL have port rst, input, 1, reset, asynchronous, active-low.
REQ-006 SHALL have port valid_in, input, 1, compressed block present.
REQ-007 SHALL have port ready_out, output, 1, block accepted when valid_in && ready_out.
REQ-008 SHALL have port max_values, input, 4 x WIDTH signed, retained coefficients.
REQ-009 SHALL have port index, input, 4 x INDEX_WIDTH, positions of max_values.
REQ-010 SHALL have port dc_value, input, WIDTH signed, DC coefficient (position 0).
REQ-011 SHALL have port data_out, output, DEPTH x WIDTH signed, one reconstructed column; element r = row r.
REQ-012 SHALL have port valid_out, output, 1, data_out valid.
REQ-013 SHALL have port ready_in, input, 1, downstream accepts column on valid_out && ready_in.
REQ-014 SHALL have port last_out, output, 1, high with valid_out on column DEPTH-1.

Function
REQ-015 SHALL implement states IDLE and EMIT plus column counter col (0..DEPTH-1).
REQ-016 SHALL assert ready_out in IDLE; in EMIT only when col==DEPTH-1 && ready_in (back-to-back accept); else low.
REQ-017 SHALL on accept register all four max_values/index pairs and dc_value, set col=0, enter EMIT.
REQ-018 SHALL assert valid_out the cycle after accept (latency 1 cycle) and hold it throughout EMIT.
REQ-019 SHALL drive data_out[r] = max_values[k] where registered index[k] == {col, r}; 0 where no slot matches.
REQ-020 SHALL resolve duplicate indices by highest slot number k winning.
REQ-021 SHALL force data_out[0] = dc_value when col==0, overriding any slot with index 0.
REQ-022 SHALL pass values through unmodified, no saturation or sign change (including -2^(WIDTH-1)).
REQ-023 SHALL advance col only on valid_out && ready_in; data_out, last_out, col stable while ready_in low.
REQ-024 SHALL on handshake at col==DEPTH-1: without simultaneous accept -> IDLE, valid_out low next cycle; with accept -> stay EMIT, col=0, new block's column 0 next cycle, no bubble.
REQ-025 SHALL ignore valid_in while ready_out low; upstream holds inputs stable.
REQ-026 SHALL drive data_out from registered state only; no combinational path from max_values/index/dc_value to data_out.

Reset
REQ-027 SHALL on rst low immediately force state IDLE, col 0, all captured registers 0.
REQ-028 SHALL hold valid_out=0, last_out=0, data_out all 0, ready_out=1 while in reset.
REQ-029 SHALL on reset mid-block discard remaining columns; first accept after release restarts at column 0.

Structure
REQ-030 SHALL take WIDTH, DEPTH, INDEX_WIDTH, NUM_COEFFS=4 and state enum from shared package compression_pkg, also used by the compression side.
REQ-031 SHALL place per-column scatter (REQ-019..021) in combinational sub-module coeff_column_scatter; FSM, counter, capture registers in top.

Verification
REQ-032 SHALL test dc=100, max={50,-30,20,0}, index={9,17,63,2} -> col0 row0=100, col1 row1=50, col2 row1=-30, col7 row7=20, all else 0; 8 beats; last_out on 8th only.
REQ-033 SHALL test ready_in toggling 1,0,1,0... -> each column held while ready_in low, 8 handshakes over 16 cycles, order unchanged.
REQ-034 SHALL test second block offered during col7 handshake -> ready_out=1 that cycle, accepted, its col0 appears next cycle, valid_out never drops.
REQ-035 SHALL test index={5,5,5,5}, max={1,2,3,4} -> col0 row5=4; index={0,...} max[0]=7, dc=9 -> col0 row0=9.
REQ-036 SHALL test rst low during col 3 -> outputs 0, ready_out=1; new block after release emits from col0.
REQ-037 SHALL test max=-32768 at index 36 -> col4 row4 = -32768 exactly.

Source files
------------

// File: rtl/compression_pkg.sv
// Shared block-compression definitions: coefficient geometry, retained-slot
// count and the emitter state encoding used by both codec directions.
package compression_pkg;

  localparam int WIDTH       = 16;
  localparam int DEPTH       = 8;
  localparam int INDEX_WIDTH = 2 * $clog2(DEPTH);
  localparam int NUM_COEFFS  = 4;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_e;

endpackage

// File: rtl/coeff_column_scatter.sv
// Rebuilds one column of a DEPTH x DEPTH block from the retained slots.
// Purely combinational; later slots override earlier ones, DC overrides all.
module coeff_column_scatter
  import compression_pkg::*;
#(
  parameter int WIDTH       = compression_pkg::WIDTH,
  parameter int DEPTH       = compression_pkg::DEPTH,
  parameter int INDEX_WIDTH = compression_pkg::INDEX_WIDTH
) (
  input  logic [INDEX_WIDTH/2-1:0]          col,
  input  logic [NUM_COEFFS*WIDTH-1:0]       max_values,
  input  logic [NUM_COEFFS*INDEX_WIDTH-1:0] index,
  input  logic [WIDTH-1:0]                  dc_value,
  output logic [DEPTH*WIDTH-1:0]            data_out
);

  localparam int ROW_W = INDEX_WIDTH / 2;

  // NOTE: every output bit gets a default before any conditional write, so no
  // path through the block leaves data_out unassigned and no latch is inferred.
  always_comb begin
    data_out = '0;
    for (int r = 0; r < DEPTH; r++) begin
      // Ascending slot order lets the highest matching slot win.
      for (int k = 0; k < NUM_COEFFS; k++) begin
        if (index[k*INDEX_WIDTH +: INDEX_WIDTH] == {col, ROW_W'(r)})
          data_out[r*WIDTH +: WIDTH] = max_values[k*WIDTH +: WIDTH];
      end
    end
    if (col == '0)
      data_out[WIDTH-1:0] = dc_value;
  end

endmodule

// File: rtl/coefficient_reconstruction.sv
// Captures a compressed block (DC + four sparse coefficients) and streams the
// reconstructed block out one column per handshake, back-to-back capable.
module coefficient_reconstruction
  import compression_pkg::*;
#(
  parameter int WIDTH       = compression_pkg::WIDTH,
  parameter int DEPTH       = compression_pkg::DEPTH,
  parameter int INDEX_WIDTH = compression_pkg::INDEX_WIDTH
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              valid_in,
  output logic                              ready_out,
  input  logic [NUM_COEFFS*WIDTH-1:0]       max_values,
  input  logic [NUM_COEFFS*INDEX_WIDTH-1:0] index,
  input  logic [WIDTH-1:0]                  dc_value,
  output logic [DEPTH*WIDTH-1:0]            data_out,
  output logic                              valid_out,
  input  logic                              ready_in,
  output logic                              last_out
);

  localparam int                COL_W    = INDEX_WIDTH / 2;
  localparam logic [COL_W-1:0]  LAST_COL = COL_W'(DEPTH - 1);

  state_e                            state_q, state_d;
  logic [COL_W-1:0]                  col_q, col_d;
  logic [NUM_COEFFS*WIDTH-1:0]       max_q, max_d;
  logic [NUM_COEFFS*INDEX_WIDTH-1:0] index_q, index_d;
  logic [WIDTH-1:0]                  dc_q, dc_d;

  logic                              last_col;
  logic                              accept;
  logic                              advance;
  logic [DEPTH*WIDTH-1:0]            column;

  assign last_col  = (col_q == LAST_COL);
  // In EMIT a new block is only taken while the final column is leaving.
  assign ready_out = (state_q == IDLE) || (last_col && ready_in);
  assign accept    = valid_in && ready_out;
  assign advance   = (state_q == EMIT) && ready_in;

  assign valid_out = (state_q == EMIT);
  assign last_out  = valid_out && last_col;
  assign data_out  = valid_out ? column : '0;

  coeff_column_scatter #(
    .WIDTH       (WIDTH),
    .DEPTH       (DEPTH),
    .INDEX_WIDTH (INDEX_WIDTH)
  ) u_scatter (
    .col        (col_q),
    .max_values (max_q),
    .index      (index_q),
    .dc_value   (dc_q),
    .data_out   (column)
  );

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    max_d   = max_q;
    index_d = index_q;
    dc_d    = dc_q;
    if (accept) begin
      state_d = EMIT;
      col_d   = '0;
      max_d   = max_values;
      index_d = index_values_pass(index);
      dc_d    = dc_value;
    end else if (advance) begin
      if (last_col) begin
        state_d = IDLE;
        col_d   = '0;
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end
  end

  function automatic logic [NUM_COEFFS*INDEX_WIDTH-1:0] index_values_pass(
    input logic [NUM_COEFFS*INDEX_WIDTH-1:0] v
  );
    return v;
  endfunction

  // NOTE: state is updated with non-blocking assignments only, and every
  // captured register is cleared by the asynchronous reset so no stale block
  // data can leak onto data_out after a mid-block reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      col_q   <= '0;
      max_q   <= '0;
      index_q <= '0;
      dc_q    <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      max_q   <= max_d;
      index_q <= index_d;
      dc_q    <= dc_d;
    end
  end

endmodule

// File: tb/tb_coefficient_reconstruction.sv
// Directed bench for coefficient_reconstruction: table of blocks with
// hand-resolved nonzero positions, plus stall, back-to-back and reset runs.
module tb_coefficient_reconstruction;

  localparam int W  = 16;
  localparam int D  = 8;
  localparam int IW = 6;

  typedef struct packed {
    logic [3:0][W-1:0]  mx;
    logic [3:0][IW-1:0] ix;
    logic [W-1:0]       dc;
    logic [3:0]         hvld;
    logic [3:0][2:0]    hc;
    logic [3:0][2:0]    hr;
    logic [3:0][W-1:0]  hv;
  } vec_t;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              valid_in = 1'b0;
  logic              ready_in = 1'b0;
  logic              ready_out;
  logic [4*W-1:0]    max_values = '0;
  logic [4*IW-1:0]   index = '0;
  logic [W-1:0]      dc_value = '0;
  logic [D*W-1:0]    data_out;
  logic              valid_out;
  logic              last_out;

  int n_checks = 0;
  int n_fail   = 0;
  vec_t vecs[4];

  always #5 clk = ~clk;

  coefficient_reconstruction dut (
    .clk        (clk),
    .rst        (rst),
    .valid_in   (valid_in),
    .ready_out  (ready_out),
    .max_values (max_values),
    .index      (index),
    .dc_value   (dc_value),
    .data_out   (data_out),
    .valid_out  (valid_out),
    .ready_in   (ready_in),
    .last_out   (last_out)
  );

  task automatic check(input string name, input logic [D*W-1:0] act, input logic [D*W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [D*W-1:0] exp_col(input vec_t v, input int c);
    logic [D*W-1:0] e;
    e = '0;
    for (int h = 0; h < 4; h++)
      if (v.hvld[h] && int'(v.hc[h]) == c)
        e[int'(v.hr[h])*W +: W] = v.hv[h];
    return e;
  endfunction

  task automatic drive(input vec_t v);
    max_values = v.mx;
    index      = v.ix;
    dc_value   = v.dc;
    valid_in   = 1'b1;
  endtask

  task automatic run_block(input string tag, input vec_t v);
    @(negedge clk);
    check({tag, " idle ready_out"}, ready_out, 1);
    check({tag, " idle valid_out"}, valid_out, 0);
    drive(v);
    ready_in = 1'b1;
    @(posedge clk);
    #1 valid_in = 1'b0;
    for (int c = 0; c < D; c++) begin
      @(negedge clk);
      check($sformatf("%s col%0d valid_out", tag, c), valid_out, 1);
      check($sformatf("%s col%0d data_out", tag, c), data_out, exp_col(v, c));
      check($sformatf("%s col%0d last_out", tag, c), last_out, (c == D-1));
      if (c == 3)
        check($sformatf("%s col3 ready_out", tag), ready_out, 0);
    end
    @(negedge clk);
    check({tag, " end valid_out"}, valid_out, 0);
    check({tag, " end data_out"}, data_out, 0);
  endtask

  initial begin
    vecs = '{default: '0};
    // Block 0: dc=100, max={50,-30,20,0}, index={9,17,63,2}
    vecs[0].mx[0] = 16'd50;  vecs[0].mx[1] = -16'sd30;
    vecs[0].mx[2] = 16'd20;  vecs[0].mx[3] = 16'd0;
    vecs[0].ix[0] = 6'd9;    vecs[0].ix[1] = 6'd17;
    vecs[0].ix[2] = 6'd63;   vecs[0].ix[3] = 6'd2;
    vecs[0].dc    = 16'd100;
    vecs[0].hvld  = 4'b1111;
    vecs[0].hc[0] = 3'd0; vecs[0].hr[0] = 3'd0; vecs[0].hv[0] = 16'd100;
    vecs[0].hc[1] = 3'd1; vecs[0].hr[1] = 3'd1; vecs[0].hv[1] = 16'd50;
    vecs[0].hc[2] = 3'd2; vecs[0].hr[2] = 3'd1; vecs[0].hv[2] = 16'hffe2;
    vecs[0].hc[3] = 3'd7; vecs[0].hr[3] = 3'd7; vecs[0].hv[3] = 16'd20;
    // Block 1: all slots at index 5 -> slot 3 (value 4) wins
    vecs[1].mx[0] = 16'd1; vecs[1].mx[1] = 16'd2;
    vecs[1].mx[2] = 16'd3; vecs[1].mx[3] = 16'd4;
    vecs[1].ix[0] = 6'd5;  vecs[1].ix[1] = 6'd5;
    vecs[1].ix[2] = 6'd5;  vecs[1].ix[3] = 6'd5;
    vecs[1].dc    = 16'd0;
    vecs[1].hvld  = 4'b0001;
    vecs[1].hc[0] = 3'd0; vecs[1].hr[0] = 3'd5; vecs[1].hv[0] = 16'd4;
    // Block 2: slot 0 at index 0 with 7, dc=9 overrides it
    vecs[2].mx[0] = 16'd7;  vecs[2].mx[1] = 16'hffff;
    vecs[2].mx[2] = 16'd2;  vecs[2].mx[3] = 16'd3;
    vecs[2].ix[0] = 6'd0;   vecs[2].ix[1] = 6'd18;
    vecs[2].ix[2] = 6'd27;  vecs[2].ix[3] = 6'd45;
    vecs[2].dc    = 16'd9;
    vecs[2].hvld  = 4'b1111;
    vecs[2].hc[0] = 3'd0; vecs[2].hr[0] = 3'd0; vecs[2].hv[0] = 16'd9;
    vecs[2].hc[1] = 3'd2; vecs[2].hr[1] = 3'd2; vecs[2].hv[1] = 16'hffff;
    vecs[2].hc[2] = 3'd3; vecs[2].hr[2] = 3'd3; vecs[2].hv[2] = 16'd2;
    vecs[2].hc[3] = 3'd5; vecs[2].hr[3] = 3'd5; vecs[2].hv[3] = 16'd3;
    // Block 3: extremes -32768 at 36, 32767 at 35, dc=-5 over two index-0 slots
    vecs[3].mx[0] = 16'h8000; vecs[3].mx[1] = 16'h7fff;
    vecs[3].mx[2] = 16'd11;   vecs[3].mx[3] = 16'd12;
    vecs[3].ix[0] = 6'd36;    vecs[3].ix[1] = 6'd35;
    vecs[3].ix[2] = 6'd0;     vecs[3].ix[3] = 6'd0;
    vecs[3].dc    = 16'hfffb;
    vecs[3].hvld  = 4'b0111;
    vecs[3].hc[0] = 3'd4; vecs[3].hr[0] = 3'd4; vecs[3].hv[0] = 16'h8000;
    vecs[3].hc[1] = 3'd4; vecs[3].hr[1] = 3'd3; vecs[3].hv[1] = 16'h7fff;
    vecs[3].hc[2] = 3'd0; vecs[3].hr[2] = 3'd0; vecs[3].hv[2] = 16'hfffb;

    // Reset state
    #12;
    check("reset valid_out", valid_out, 0);
    check("reset last_out", last_out, 0);
    check("reset data_out", data_out, 0);
    check("reset ready_out", ready_out, 1);
    @(negedge clk);
    rst = 1'b1;

    // Table-driven blocks at full throughput
    for (int i = 0; i < 4; i++)
      run_block($sformatf("blk%0d", i), vecs[i]);

    // ready_in toggling 1,0,1,0...: one column per two cycles
    begin
      int hs;
      hs = 0;
      @(negedge clk);
      drive(vecs[0]);
      ready_in = 1'b1;
      @(posedge clk);
      #1 valid_in = 1'b0;
      for (int cyc = 0; cyc < 16; cyc++) begin
        ready_in = (cyc % 2 == 0);
        @(negedge clk);
        if (hs < D) begin
          check($sformatf("stall cyc%0d data_out", cyc), data_out, exp_col(vecs[0], hs));
          check($sformatf("stall cyc%0d last_out", cyc), last_out, (hs == D-1));
          check($sformatf("stall cyc%0d valid_out", cyc), valid_out, 1);
        end else begin
          check($sformatf("stall cyc%0d valid_out", cyc), valid_out, 0);
        end
        @(posedge clk);
        if (ready_in) hs++;
        #1;
      end
      ready_in = 1'b1;
    end

    // Back-to-back: second block offered during column 7 handshake
    @(negedge clk);
    drive(vecs[0]);
    @(posedge clk);
    #1 valid_in = 1'b0;
    for (int c = 0; c < D; c++) begin
      @(negedge clk);
      check($sformatf("b2b A col%0d data_out", c), data_out, exp_col(vecs[0], c));
      check($sformatf("b2b A col%0d valid_out", c), valid_out, 1);
      if (c == D-1) begin
        check("b2b col7 ready_out", ready_out, 1);
        drive(vecs[3]);
      end
    end
    @(posedge clk);
    #1 valid_in = 1'b0;
    for (int c = 0; c < D; c++) begin
      @(negedge clk);
      check($sformatf("b2b B col%0d valid_out", c), valid_out, 1);
      check($sformatf("b2b B col%0d data_out", c), data_out, exp_col(vecs[3], c));
      check($sformatf("b2b B col%0d last_out", c), last_out, (c == D-1));
    end
    @(negedge clk);
    check("b2b end valid_out", valid_out, 0);

    // Reset during column 3, then a fresh block restarts at column 0
    @(negedge clk);
    drive(vecs[0]);
    @(posedge clk);
    #1 valid_in = 1'b0;
    for (int c = 0; c < 4; c++) @(negedge clk);
    check("pre-reset col3 data_out", data_out, exp_col(vecs[0], 3));
    rst = 1'b0;
    #1;
    check("midrst valid_out", valid_out, 0);
    check("midrst last_out", last_out, 0);
    check("midrst data_out", data_out, 0);
    check("midrst ready_out", ready_out, 1);
    @(posedge clk);
    @(negedge clk);
    check("midrst held valid_out", valid_out, 0);
    rst = 1'b1;
    run_block("post-reset", vecs[2]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
